inverse_demo: RTL

Iterative inverse of the `demo` datapath: given a target `y`, finds the largest integer `x` with `x*x + 2*x <= y` and reports whether equality holds. It is built from a controller FSM plus a register/ALU datapath. It shares the `go`/`done` handshake style of `demo`. It sits beside `demo` on the board-level wrapper so a result from one can be fed back through the other.

---
 rtl/inverse_demo.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/inverse_demo.sv
`default_nettype none
// ============================================================================
//  Module   : inverse_demo
//  Purpose  : Iterative inverse of the demo datapath. Given target y, finds
//             the largest x with x*x + 2*x <= y and flags equality. Built as
//             a controller FSM driving a small register/ALU datapath, with
//             a level-sensitive go / done handshake.
//  Ports    : clk     - system clock, rising-edge active
//             resetn  - synchronous active-low reset
//             go      - start request (level, active-high)
//             y[7:0]  - target value, captured only in IDLE
//             done    - result valid, FSM in DONE
//             busy    - search in progress (SQUARE..CHECK)
//             x[7:0]  - result, upper nibble always zero
//             exact   - x*x + 2*x == y
//  Revision : 1.0  initial release
// ============================================================================
module inverse_demo (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic [7:0] y,
  output logic       done,
  output logic       busy,
  output logic [7:0] x,
  output logic       exact
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SQUARE = 3'd1,
    S_DOUBLE = 3'd2,
    S_SUM    = 3'd3,
    S_CHECK  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] ry_q,    ry_d;
  logic [3:0] rx_q,    rx_d;
  logic [8:0] ra_q,    ra_d;
  logic [8:0] rb_q,    rb_d;
  logic [3:0] xout_q,  xout_d;
  logic       exout_q, exout_d;

  // ALU operand selection, kept apart from the next-state logic so the
  // ALU result never feeds back into the block that chooses its inputs.
  logic       alu_mul;
  logic [8:0] alu_a;
  logic [8:0] alu_b;
  logic [8:0] alu_y;

  always_comb begin
    alu_mul = 1'b0;
    alu_a   = 9'd0;
    alu_b   = 9'd0;
    case (state_q)
      S_SQUARE: begin
        alu_mul = 1'b1;
        alu_a   = {5'd0, rx_q};
        alu_b   = {5'd0, rx_q};
      end
      S_DOUBLE: begin
        alu_a   = {5'd0, rx_q};
        alu_b   = {5'd0, rx_q};
      end
      S_SUM: begin
        alu_a   = ra_q;
        alu_b   = rb_q;
      end
      default: ;
    endcase
  end

  // 9 bits are enough: the largest value ever formed is 15*15 + 30 = 255.
  assign alu_y = alu_mul ? (alu_a * alu_b) : (alu_a + alu_b);

  // Next-state and datapath control
  always_comb begin
    state_d = state_q;
    ry_d    = ry_q;
    rx_d    = rx_q;
    ra_d    = ra_q;
    rb_d    = rb_q;
    xout_d  = xout_q;
    exout_d = exout_q;
    case (state_q)
      S_IDLE: begin
        if (go) begin
          ry_d    = y;
          rx_d    = 4'd0;
          state_d = S_SQUARE;
        end
      end
      S_SQUARE: begin
        ra_d    = alu_y;
        state_d = S_DOUBLE;
      end
      S_DOUBLE: begin
        rb_d    = alu_y;
        state_d = S_SUM;
      end
      S_SUM: begin
        ra_d    = alu_y;
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (ra_q == {1'b0, ry_q}) begin
          xout_d  = rx_q;
          exout_d = 1'b1;
          state_d = S_DONE;
        end else if (ra_q > {1'b0, ry_q}) begin
          // Overshoot: previous candidate was the answer. rx_q >= 1 here,
          // since candidate 0 always yields 0 <= y.
          xout_d  = rx_q - 4'd1;
          exout_d = 1'b0;
          state_d = S_DONE;
        end else begin
          // Candidate 15 yields 255 >= any y, so this never wraps.
          rx_d    = rx_q + 4'd1;
          state_d = S_SQUARE;
        end
      end
      S_DONE: begin
        if (!go) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      ry_q    <= 8'd0;
      rx_q    <= 4'd0;
      ra_q    <= 9'd0;
      rb_q    <= 9'd0;
      xout_q  <= 4'd0;
      exout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ry_q    <= ry_d;
      rx_q    <= rx_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      xout_q  <= xout_d;
      exout_q <= exout_d;
    end
  end

  // Status outputs decode registered state only.
  assign busy  = (state_q == S_SQUARE) || (state_q == S_DOUBLE) ||
                 (state_q == S_SUM)    || (state_q == S_CHECK);
  assign done  = (state_q == S_DONE);
  assign x     = {4'd0, xout_q};
  assign exact = exout_q;

endmodule
`default_nettype wire
